bank_rr_arbiter: RTL

- Per-memory-bank round-robin arbiter sitting directly downstream of the per-PE request FIFOs (synch_fifo).
- Collects the one request bit per PE FIFO addressed to this bank, plus each FIFO's head entry, and grants one PE per cycle.
- The grant is returned to the FIFO as its nxt_gnt pop bit; the winning entry is registered onto a valid/ready bank command port.
- One instance per bank, MEM_BANK_NUM instances in total.

---
 rtl/bank_rr_arbiter_if.sv | 44 ++++
 rtl/bank_rr_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/bank_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// bank_rr_arbiter_if
//
// Bundles the signals between the per-PE request FIFOs, one bank arbiter and
// the memory bank command port.
//
// Signals:
//   req        FIFO -> arb   per-PE "head entry targets this bank" bit
//   req_data   FIFO -> arb   head entries, PE i at [i*FIFO_WIDTH +: FIFO_WIDTH]
//   bank_ready bank -> arb   bank accepts the registered command this cycle
//   gnt        arb -> FIFO   one-hot or zero pop strobe (nxt_gnt)
//   bank_vld   arb -> bank   registered command valid
//   bank_data  arb -> bank   registered payload of the granted entry
//   bank_src   arb -> bank   registered index of the granted PE
//   rr_ptr     arb -> debug  current highest-priority PE index
//   id_err     arb -> debug  sticky: a granted entry carried a foreign bank id
//
// Modports: slave = arbiter side, master = FIFO/bank/testbench side.
// -----------------------------------------------------------------------------
interface bank_rr_arbiter_if #(
    parameter int PEA_NUM    = 16,
    parameter int FIFO_WIDTH = 36,
    parameter int SRC_W      = 4
);
    logic [PEA_NUM-1:0]            req;
    logic [PEA_NUM*FIFO_WIDTH-1:0] req_data;
    logic                          bank_ready;
    logic [PEA_NUM-1:0]            gnt;
    logic                          bank_vld;
    logic [FIFO_WIDTH-5:0]         bank_data;
    logic [SRC_W-1:0]              bank_src;
    logic [SRC_W-1:0]              rr_ptr;
    logic                          id_err;

    modport slave (
        input  req, req_data, bank_ready,
        output gnt, bank_vld, bank_data, bank_src, rr_ptr, id_err
    );

    modport master (
        output req, req_data, bank_ready,
        input  gnt, bank_vld, bank_data, bank_src, rr_ptr, id_err
    );
endinterface

// File: rtl/bank_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bank_rr_arbiter
//
// Round-robin arbiter for one memory bank. Picks one requesting PE FIFO per
// cycle starting from rr_ptr, pops it through gnt (combinational) and
// registers the winning payload onto a valid/ready bank command port.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   bus        bank_rr_arbiter_if.slave (req/req_data/bank_ready in,
//              gnt/bank_vld/bank_data/bank_src/rr_ptr/id_err out)
//   grant_cnt  (BANK_ARB_STAT_EN only) saturating count of grant edges
//   stall_cnt  (BANK_ARB_STAT_EN only) saturating count of stalled edges
//
// Optional feature macro: BANK_ARB_STAT_EN adds the two statistics counters.
// -----------------------------------------------------------------------------
module bank_rr_arbiter #(
    parameter int PEA_NUM    = 16,
    parameter int FIFO_WIDTH = 36,
    parameter int SRC_W      = 4,
    parameter int BANK_ID    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef BANK_ARB_STAT_EN
    output logic [15:0]            grant_cnt,
    output logic [15:0]            stall_cnt,
`endif
    bank_rr_arbiter_if.slave       bus
);

    logic                  bank_vld_q, bank_vld_d;
    logic [FIFO_WIDTH-5:0] bank_data_q, bank_data_d;
    logic [SRC_W-1:0]      bank_src_q, bank_src_d;
    logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  id_err_q, id_err_d;

    logic                  can_grant;
    logic                  winner_found;
    logic [SRC_W-1:0]      winner_idx;
    logic                  grant_fire;
    logic [FIFO_WIDTH-1:0] win_entry;
    logic [PEA_NUM-1:0]    gnt_vec;
    int                    scan_idx;

    // Output register is empty or being drained this cycle.
    assign can_grant = !bank_vld_q || bus.bank_ready;

    // Scan from rr_ptr upward with wrap; the first set request wins. The
    // explicit wrap keeps this correct for non-power-of-two PEA_NUM.
    always_comb begin
        winner_found = 1'b0;
        winner_idx   = '0;
        scan_idx     = 0;
        for (int k = 0; k < PEA_NUM; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= PEA_NUM) begin
                scan_idx = scan_idx - PEA_NUM;
            end
            if (!winner_found && bus.req[scan_idx]) begin
                winner_found = 1'b1;
                winner_idx   = SRC_W'(scan_idx);
            end
        end
    end

    // gnt is held low during reset so no FIFO pops an entry that the
    // cleared output register would then lose.
    assign grant_fire = can_grant && winner_found && !rst;
    assign win_entry  = bus.req_data[int'(winner_idx)*FIFO_WIDTH +: FIFO_WIDTH];

    always_comb begin
        gnt_vec = '0;
        if (grant_fire) begin
            gnt_vec[winner_idx] = 1'b1;
        end
    end

    always_comb begin
        bank_vld_d  = bank_vld_q;
        bank_data_d = bank_data_q;
        bank_src_d  = bank_src_q;
        rr_ptr_d    = rr_ptr_q;
        id_err_d    = id_err_q;
        if (grant_fire) begin
            bank_vld_d  = 1'b1;
            bank_data_d = win_entry[FIFO_WIDTH-5:0];
            bank_src_d  = winner_idx;
            rr_ptr_d    = (winner_idx == SRC_W'(PEA_NUM-1)) ? '0 : winner_idx + 1'b1;
            if (win_entry[FIFO_WIDTH-1 -: 4] != 4'(BANK_ID)) begin
                id_err_d = 1'b1;
            end
        end else if (bus.bank_ready) begin
            bank_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_vld_q  <= 1'b0;
            bank_data_q <= '0;
            bank_src_q  <= '0;
            rr_ptr_q    <= '0;
            id_err_q    <= 1'b0;
        end else begin
            bank_vld_q  <= bank_vld_d;
            bank_data_q <= bank_data_d;
            bank_src_q  <= bank_src_d;
            rr_ptr_q    <= rr_ptr_d;
            id_err_q    <= id_err_d;
        end
    end

    assign bus.gnt       = gnt_vec;
    assign bus.bank_vld  = bank_vld_q;
    assign bus.bank_data = bank_data_q;
    assign bus.bank_src  = bank_src_q;
    assign bus.rr_ptr    = rr_ptr_q;
    assign bus.id_err    = id_err_q;

`ifdef BANK_ARB_STAT_EN
    logic [15:0] grant_cnt_q, grant_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (grant_fire && grant_cnt_q != 16'hFFFF) begin
            grant_cnt_d = grant_cnt_q + 16'd1;
        end
        if (bank_vld_q && !bus.bank_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
